// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared encodings for the multi-cycle divider controller
package div_ctrl_pkg;
  typedef logic [1:0] div_state_t;
  localparam div_state_t DivFree   = 2'b00;
  localparam div_state_t DivByZero = 2'b01;
  localparam div_state_t DivOn     = 2'b10;
  localparam div_state_t DivEnd    = 2'b11;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  function automatic logic [31:0] neg_if(input logic c, input logic [31:0] v);
    return c ? -v : v;
  endfunction
endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: EX-stage to divider request/result bundle
interface div_ctrl_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;
  modport master (output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
                  input result_o, ready_o, stallreq_o);
  modport slave  (input signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
                  output result_o, ready_o, stallreq_o);
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: 32-step restoring divider, signed/unsigned, result = {remainder, quotient}
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);
  div_state_t  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] w_q, w_d, w_step;
  logic [31:0] d_q, d_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [63:0] res_q, res_d;
  logic        ready_q, ready_d;
  logic [32:0] diff;
  // w[64:32] is the pre-shifted partial remainder; quotient bits enter at w[0]
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    d_d     = d_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    diff    = w_q[64:32] - {1'b0, d_q};
    w_step  = {diff[32] ? w_q[63:32] : diff[31:0], w_q[31:0], ~diff[32]};
    case (state_q)
      DivFree: if (bus.start_i == DivStart && !bus.annul_i) begin
        state_d = (bus.opdata2_i == '0) ? DivByZero : DivOn;
        cnt_d   = '0;
        sa_d    = bus.signed_div_i & bus.opdata1_i[31];
        sb_d    = bus.signed_div_i & bus.opdata2_i[31];
        w_d     = {32'b0, neg_if(bus.signed_div_i & bus.opdata1_i[31], bus.opdata1_i), 1'b0};
        d_d     = neg_if(bus.signed_div_i & bus.opdata2_i[31], bus.opdata2_i);
      end
      DivByZero: begin
        res_d   = '0;
        state_d = DivEnd;
      end
      DivOn: if (bus.annul_i) begin
        state_d = DivFree;
        cnt_d   = '0;
      end else begin
        w_d   = w_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DivEnd;
          res_d   = {neg_if(sa_q, w_step[64:33]), neg_if(sa_q ^ sb_q, w_step[31:0])};
        end
      end
      default: if (bus.start_i == DivStop) state_d = DivFree;
    endcase
    ready_d = (state_q == DivEnd && bus.start_i == DivStart) ? DivResultReady : DivResultNotReady;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DivFree;
      cnt_q   <= '0;
      w_q     <= '0;
      d_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      res_q   <= '0;
      ready_q <= DivResultNotReady;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      d_q     <= d_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      ready_q <= ready_d;
    end
  end
  assign bus.result_o   = res_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~ready_q & ~bus.annul_i;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of div_ctrl results, latency, annul and reset
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;
  div_ctrl_if bus();
  div_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    int          lat;
  } vec_t;
  vec_t v [7] = '{
    '{1'b0, 32'd100,        32'd7,          {32'h00000002, 32'h0000000E}, 34},
    '{1'b1, 32'hFFFFFFF9,   32'h00000002,   {32'hFFFFFFFF, 32'hFFFFFFFD}, 34},
    '{1'b0, 32'd12345,      32'h00000000,   64'h0,                        3},
    '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 34},
    '{1'b0, 32'hFFFFFFFF,   32'h00000001,   {32'h00000000, 32'hFFFFFFFF}, 34},
    '{1'b1, 32'h00000007,   32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 34},
    '{1'b0, 32'hFFFFFFFF,   32'h80000001,   {32'h7FFFFFFE, 32'h00000001}, 34}
  };
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
  endtask
  // operands are scrambled right after the sampling edge; the result must not care
  task automatic await_ready(input string tag, input int exp_n);
    int n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        bus.opdata1_i    = 32'hDEADBEEF;
        bus.opdata2_i    = 32'h0;
        bus.signed_div_i = ~bus.signed_div_i;
      end
    end while (!bus.ready_o && n < 60);
    chk({tag, " latency"}, 64'(n), 64'(exp_n));
  endtask
  task automatic finish_op(input string tag, input logic [63:0] exp);
    chk({tag, " result"}, bus.result_o, exp);
    chk({tag, " stall"}, 64'(bus.stallreq_o), 64'd0);
    tick();
    chk({tag, " held ready"}, 64'(bus.ready_o), 64'd1);
    chk({tag, " held result"}, bus.result_o, exp);
    bus.start_i = 1'b0;
    tick();
    chk({tag, " drop ready"}, 64'(bus.ready_o), 64'd0);
    tick();
  endtask
  initial begin
    logic seen;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    tick();
    tick();
    chk("reset ready", 64'(bus.ready_o), 64'd0);
    chk("reset result", bus.result_o, 64'd0);
    chk("reset stall", 64'(bus.stallreq_o), 64'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      launch(v[i].s, v[i].a, v[i].b);
      #1;
      chk($sformatf("vec%0d stall", i), 64'(bus.stallreq_o), 64'd1);
      await_ready($sformatf("vec%0d", i), v[i].lat);
      finish_op($sformatf("vec%0d", i), v[i].r);
    end
    launch(1'b0, 32'd50, 32'd5);
    bus.annul_i = 1'b1;
    #1;
    chk("annul free stall", 64'(bus.stallreq_o), 64'd0);
    tick();
    bus.annul_i = 1'b0;
    await_ready("annul free", 34);
    finish_op("annul free", {32'd0, 32'd10});
    launch(1'b0, 32'd1000, 32'd10);
    repeat (11) tick();
    bus.annul_i = 1'b1;
    #1;
    chk("annul on stall", 64'(bus.stallreq_o), 64'd0);
    tick();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= bus.ready_o;
    end
    chk("annul on never ready", 64'(seen), 64'd0);
    chk("annul on result kept", bus.result_o, {32'd0, 32'd10});
    launch(1'b0, 32'd1000, 32'd10);
    await_ready("after annul", 34);
    finish_op("after annul", {32'd0, 32'd100});
    launch(1'b0, 32'd100, 32'd7);
    repeat (21) tick();
    rst = 1'b1;
    tick();
    chk("midrst ready", 64'(bus.ready_o), 64'd0);
    chk("midrst result", bus.result_o, 64'd0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    #1;
    chk("midrst stall", 64'(bus.stallreq_o), 64'd0);
    tick();
    launch(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9);
    await_ready("after rst", 34);
    finish_op("after rst", {32'hFFFFFFFE, 32'h0000000E});
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-004 SHALL have port opdata1_i  input  32  dividend; sampled with start.
REQ-005 SHALL have port opdata2_i  input  32  divisor; sampled with start.
REQ-006 SHALL have port start_i  input  1  request from EX stage; held high until result consumed.
REQ-007 SHALL have port annul_i  input  1  cancel in-flight division (pipeline flush).
REQ-008 SHALL have port result_o  output  64  {remainder, quotient}; HI = [63:32], LO = [31:0].
REQ-009 SHALL have port ready_o  output  1  result_o valid.
REQ-010 SHALL have port stallreq_o  output  1  combinational stall request to pipeline controller.

Function
REQ-011 SHALL implement FSM states FREE, BYZERO, ON, END.
REQ-012 FREE: start_i=1, annul_i=0, divisor==0 -> BYZERO; start_i=1, annul_i=0, divisor!=0 -> ON, cnt=0, operands latched; else stay FREE.
REQ-013 Signed mode: latched operands SHALL be absolute values; dividend sign and divisor sign SHALL be stored for correction.
REQ-014 BYZERO: next edge SHALL load result register with 0 and go to END.
REQ-015 ON with annul_i=0: each edge SHALL perform one restoring shift-subtract step (33-bit partial remainder, 1 quotient bit) and increment 6-bit cnt.
REQ-016 ON: on the edge where cnt==31, final step SHALL complete, sign correction SHALL be applied, result register loaded, state -> END.
REQ-017 Sign correction: quotient negated (two's complement) when dividend and divisor signs differ; remainder negated when dividend negative.
REQ-018 ON with annul_i=1: state SHALL go to FREE, cnt cleared, result register unchanged, ready_o stays 0.
REQ-019 END: ready_o=1, result_o stable; start_i=0 -> FREE with ready_o=0 next cycle; start_i=1 -> stay END.
REQ-020 Latency: start sampled at edge N, nonzero divisor -> ready_o=1 from edge N+33; zero divisor -> from edge N+2.
REQ-021 stallreq_o SHALL equal (start_i & ~ready_o & ~annul_i).
REQ-022 Overflow 0x80000000 / 0xFFFFFFFF signed SHALL wrap: quotient 0x80000000, remainder 0; no exception.
REQ-023 Inputs SHALL be ignored in ON, BYZERO and END, except start_i and annul_i.
REQ-024 annul_i in FREE SHALL block a start in the same cycle.

Reset
REQ-025 rst=1 at an edge SHALL force state FREE, cnt=0, result register 0, ready_o=0, sign flags 0.
REQ-026 rst SHALL override annul_i and start_i, including mid-division.

Structure
REQ-027 State encodings (DivFree, DivByZero, DivOn, DivEnd) and DivStart/DivStop, DivResultReady/NotReady SHALL be defined in the shared defines file.
REQ-028 No sub-module: the subtract step is a single 33-bit subtraction inline; single module, target 150-250 lines.
REQ-029 State, cnt, the working register (65-bit {remainder, dividend}) and result SHALL be registered; stallreq_o is the only combinational output.

Verification
REQ-030 Unsigned 100 / 7 -> after 33 cycles result_o = {0x00000002, 0x0000000E}, ready_o=1.
REQ-031 Signed -7 / 2 (0xFFFFFFF9, 0x2) -> {0xFFFFFFFF, 0xFFFFFFFD}.
REQ-032 Divisor 0, any dividend -> ready_o=1 two cycles after start, result_o = 0.
REQ-033 annul_i pulsed at ON cycle 10 -> FREE next cycle, ready_o never asserts; a new start then gives a correct result.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 1 -> {0x0, 0xFFFFFFFF}.
REQ-035 rst asserted at ON cycle 20 -> next cycle all outputs 0, state FREE. Holding start_i in END keeps result stable; dropping it clears ready_o next cycle.
